fifo_uart_tx: RTL

Serial transmitter that drains the async FIFO from its read side. It runs in the FIFO read clock domain and watches EMPTY. It pops one word with a single-cycle R_INC and shifts that word out as a UART frame: start bit, data LSB-first, optional parity, stop bit. One bit is sent per R_CLK cycle; R_CLK is already the baud clock, and the prescaler lives upstream.

---
 rtl/fifo_uart_tx_pkg.sv | 15 +
 rtl/fifo_uart_tx_if.sv | 11 +
 rtl/fifo_uart_tx_parity.sv | 16 +
 rtl/fifo_uart_tx.sv | 121 ++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared types for the FIFO-draining UART transmitter.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side handshake between the read-pointer block (master) and the transmitter (slave).
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  EMPTY;
  logic [DATA_WIDTH-1:0] RD_DATA;
  logic                  R_INC;

  modport master (output EMPTY, output RD_DATA, input  R_INC);
  modport slave  (input  EMPTY, input  RD_DATA, output R_INC);
endinterface

// File: rtl/fifo_uart_tx_parity.sv
// Parity bit for one FIFO word: even = XOR of all bits, odd = its inverse.
module fifo_uart_tx_parity
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  always_comb begin
    par_bit = (par_typ == PAR_EVEN) ? (^data) : (~^data);
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter in the FIFO read/baud domain: pops one word per frame and
// sends start, LSB-first data, optional parity and stop, one bit per R_CLK.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic           R_CLK,
  input  logic           R_RST,
  fifo_uart_tx_if.slave  fifo,
  input  logic           PAR_EN,
  input  logic           PAR_TYP,
  output logic           TX_OUT,
  output logic           BUSY
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  tx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  load;
  logic                  par_calc;

  // EMPTY is only looked at when the line is free to take a new frame.
  assign load       = ((state_q == IDLE) || (state_q == STOP)) && !fifo.EMPTY;
  assign fifo.R_INC = load & R_RST;
  assign TX_OUT     = tx_q;
  assign BUSY       = busy_q;

  fifo_uart_tx_parity #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data    (fifo.RD_DATA),
    .par_typ (PAR_TYP),
    .par_bit (par_calc)
  );

  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // Outputs are computed for the state being entered, so the registered
  // line value covers exactly the cycle spent in that state.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    unique case (state_q)
      IDLE, STOP: begin
        if (load) begin
          state_d   = START;
          shift_d   = fifo.RD_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = par_calc;
          cnt_d     = '0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end else begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      START: begin
        state_d = DATA;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_bit_q;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d   = cnt_q + CW'(1);
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      PARITY: begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule
